// File: rtl/cic_comb_pkg.sv
// cic_comb_pkg
// Shared defaults and helpers for the CIC comb section.
//   N_DEF / M_DEF : default input / output widths
//   R_DEF         : default decimation ratio
//   D_DEF         : default differential delay
//   cnt_width()   : decimation counter width, never narrower than 1 bit
package cic_comb_pkg;

    localparam int N_DEF = 17;
    localparam int M_DEF = 17;
    localparam int R_DEF = 4;
    localparam int D_DEF = 1;

    // r == 1 still needs a 1-bit counter so the compare logic stays uniform
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/cic_comb.sv
// cic_comb
// Decimating comb stage of a CIC filter. Samples the integrator output once
// every r clocks, subtracts the value sampled d decimated samples earlier and
// presents the m MSBs of the wrapped difference.
//   clk : clock, all state updates on posedge
//   clr : asynchronous active-high reset
//   in  : n-bit signed integrator output, one sample per clk
//   out : m-bit signed decimated comb result (registered)
//   str : one-cycle strobe, high while out holds a freshly updated value
module cic_comb
    import cic_comb_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int m = M_DEF,
    parameter int r = R_DEF,
    parameter int d = D_DEF
)
(
    input  logic                clk,
    input  logic                clr,
    input  logic signed [n-1:0] in,
    output logic signed [m-1:0] out,
    output logic                str
);

    localparam int            CW       = cnt_width(r);
    localparam logic [CW-1:0] CNT_LAST = CW'(r - 1);

    logic [CW-1:0]       cnt;
    logic                sample;
    logic signed [n-1:0] diff;

    // With r == 1 the counter is pinned at 0 == CNT_LAST, so every edge samples.
    assign sample = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (sample) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delay line: stage 0 holds the newest sample, stage d-1 the oldest.
    for (genvar k = 0; k < d; k++) begin : g_dl
        logic signed [n-1:0] q;
        if (k == 0) begin : g_head
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    q <= '0;
                end else if (sample) begin
                    q <= in;
                end
            end
        end else begin : g_tap
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    q <= '0;
                end else if (sample) begin
                    q <= g_dl[k-1].q;
                end
            end
        end
    end

    // Modular subtraction: integrator overflow cancels out here.
    assign diff = in - g_dl[d-1].q;

    // Arithmetic shift then truncate keeps exactly diff[n-1:n-m], no rounding.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out <= '0;
            str <= 1'b0;
        end else begin
            str <= sample;
            if (sample) begin
                out <= m'(diff >>> (n - m));
            end
        end
    end

endmodule
